mem_calculation_unit: RTL and testbench

- Memory-stage address decoder for the pipeline data memory.
- Maps a 32-bit byte address onto one of six memory regions: trap vector (tv), reset vector (rv), text (txt), globals (glb), stack (stk) and I/O (io).
- Produces a one-hot region enable and the region-relative effective address.
- Outputs are registered: one pipeline register between decode and the memory banks.

---
 rtl/mem_calculation_unit_if.sv | 30 +++
 rtl/mem_calculation_unit.sv | 87 ++++++++
 tb/tb_mem_calculation_unit.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/mem_calculation_unit_if.sv
// rtl/mem_calculation_unit_if.sv - MEM-stage address decode bus (optional MEM_CALC_UNMAPPED_FLAG_EN adds o_unmapped_m)
interface mem_calculation_unit_if;
    logic [31:0] i_addr_m;
    logic [31:0] o_effective_addr_m;
    logic        o_tv_en;
    logic        o_rv_en;
    logic        o_txt_en;
    logic        o_glb_en;
    logic        o_stk_en;
    logic        o_io_en;
`ifdef MEM_CALC_UNMAPPED_FLAG_EN
    logic        o_unmapped_m;
`endif

    modport master (
        output i_addr_m,
        input  o_effective_addr_m, o_tv_en, o_rv_en, o_txt_en, o_glb_en, o_stk_en, o_io_en
`ifdef MEM_CALC_UNMAPPED_FLAG_EN
        , o_unmapped_m
`endif
    );

    modport slave (
        input  i_addr_m,
        output o_effective_addr_m, o_tv_en, o_rv_en, o_txt_en, o_glb_en, o_stk_en, o_io_en
`ifdef MEM_CALC_UNMAPPED_FLAG_EN
        , o_unmapped_m
`endif
    );
endinterface

// File: rtl/mem_calculation_unit.sv
// rtl/mem_calculation_unit.sv - data memory region decoder with registered one-hot enables and offset
// Optional MEM_CALC_UNMAPPED_FLAG_EN adds a registered unmapped-address flag.
module mem_calculation_unit #(
    parameter logic [31:0] REGION_SIZE = 32'h0004_0000,
    parameter logic [31:0] IO_SIZE     = 32'h0008_0000
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    mem_calculation_unit_if.slave         bus
);
    // Bases follow the fixed map; slot 3 (between txt and glb) is left as a hole.
    localparam logic [31:0] TV_BASE  = 32'h0;
    localparam logic [31:0] RV_BASE  = REGION_SIZE;
    localparam logic [31:0] TXT_BASE = REGION_SIZE * 32'd2;
    localparam logic [31:0] GLB_BASE = REGION_SIZE * 32'd4;
    localparam logic [31:0] STK_BASE = REGION_SIZE * 32'd5;
    localparam logic [31:0] IO_BASE  = REGION_SIZE * 32'd6;

    // en bit order: {tv, rv, txt, glb, stk, io}
    logic [5:0]  en_d, en_q;
    logic [31:0] eff_d, eff_q;
    logic [31:0] off_tv, off_rv, off_txt, off_glb, off_stk, off_io;

    // Unsigned wrap makes addresses below a base look huge, so one compare per region suffices.
    assign off_tv  = bus.i_addr_m - TV_BASE;
    assign off_rv  = bus.i_addr_m - RV_BASE;
    assign off_txt = bus.i_addr_m - TXT_BASE;
    assign off_glb = bus.i_addr_m - GLB_BASE;
    assign off_stk = bus.i_addr_m - STK_BASE;
    assign off_io  = bus.i_addr_m - IO_BASE;

    always_comb begin
        en_d  = 6'b000000;
        eff_d = 32'h0;
        if (off_tv < REGION_SIZE) begin
            en_d  = 6'b100000;
            eff_d = off_tv;
        end else if (off_rv < REGION_SIZE) begin
            en_d  = 6'b010000;
            eff_d = off_rv;
        end else if (off_txt < REGION_SIZE) begin
            en_d  = 6'b001000;
            eff_d = off_txt;
        end else if (off_glb < REGION_SIZE) begin
            en_d  = 6'b000100;
            eff_d = off_glb;
        end else if (off_stk < REGION_SIZE) begin
            en_d  = 6'b000010;
            eff_d = off_stk;
        end else if (off_io < IO_SIZE) begin
            en_d  = 6'b000001;
            eff_d = off_io;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            en_q  <= 6'b000000;
            eff_q <= 32'h0;
        end else begin
            en_q  <= en_d;
            eff_q <= eff_d;
        end
    end

    assign bus.o_tv_en            = en_q[5];
    assign bus.o_rv_en            = en_q[4];
    assign bus.o_txt_en           = en_q[3];
    assign bus.o_glb_en           = en_q[2];
    assign bus.o_stk_en           = en_q[1];
    assign bus.o_io_en            = en_q[0];
    assign bus.o_effective_addr_m = eff_q;

`ifdef MEM_CALC_UNMAPPED_FLAG_EN
    logic unmapped_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            unmapped_q <= 1'b0;
        end else begin
            unmapped_q <= ~|en_d;
        end
    end

    assign bus.o_unmapped_m = unmapped_q;
`endif
endmodule

// File: tb/tb_mem_calculation_unit.sv
// tb/tb_mem_calculation_unit.sv - scoreboard bench for mem_calculation_unit
module tb_mem_calculation_unit;
    typedef struct packed {
        logic [31:0] addr;
        logic [5:0]  en;
        logic [31:0] eff;
    } vec_t;

    logic   clk;
    logic   rst_n;
    vec_t   tbl[$];
    vec_t   exp_q[$];
    int     vectors     = 0;
    int     miscompares = 0;

    mem_calculation_unit_if bus ();

    mem_calculation_unit dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [5:0] dut_en();
        return {bus.o_tv_en, bus.o_rv_en, bus.o_txt_en, bus.o_glb_en, bus.o_stk_en, bus.o_io_en};
    endfunction

    task automatic check(input string name, input logic [31:0] addr, input logic [5:0] en,
                         input logic [31:0] eff, input logic unm);
        vectors++;
        if (dut_en() !== en || bus.o_effective_addr_m !== eff) begin
            miscompares++;
            $display("FAIL %s addr=%h: got en=%b eff=%h, expected en=%b eff=%h",
                     name, addr, dut_en(), bus.o_effective_addr_m, en, eff);
        end
`ifdef MEM_CALC_UNMAPPED_FLAG_EN
        vectors++;
        if (bus.o_unmapped_m !== unm) begin
            miscompares++;
            $display("FAIL %s_unmapped addr=%h: got %b, expected %b", name, addr, bus.o_unmapped_m, unm);
        end
`else
        if (unm === 1'bx) $display("unused");
`endif
    endtask

    task automatic add(input logic [31:0] addr, input logic [5:0] en, input logic [31:0] eff);
        tbl.push_back('{addr: addr, en: en, eff: eff});
    endtask

    // Monitor: any entry queued before this edge is what the edge captured.
    initial begin
        vec_t e;
        forever begin
            @(posedge clk);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                #2;
                check("scoreboard", e.addr, e.en, e.eff, (e.en == 6'b0) && rst_n);
            end else begin
                #2;
            end
            vectors++;
            if ($countones(dut_en()) > 1) begin
                miscompares++;
                $display("FAIL onehot: got en=%b, expected at most one bit set", dut_en());
            end
        end
    end

    initial begin
        // boundaries
        add(32'h0000_0000, 6'b100000, 32'h0);
        add(32'h0003_FFFF, 6'b100000, 32'h3FFFF);
        add(32'h0004_0000, 6'b010000, 32'h0);
        add(32'h0007_FFFF, 6'b010000, 32'h3FFFF);
        add(32'h0008_0000, 6'b001000, 32'h0);
        add(32'h000B_FFFF, 6'b001000, 32'h3FFFF);
        add(32'h0010_0000, 6'b000100, 32'h0);
        add(32'h0013_FFFF, 6'b000100, 32'h3FFFF);
        add(32'h0014_0000, 6'b000010, 32'h0);
        add(32'h0017_FFFF, 6'b000010, 32'h3FFFF);
        add(32'h0018_0000, 6'b000001, 32'h0);
        add(32'h001F_FFFF, 6'b000001, 32'h7FFFF);
        // interior offsets
        add(32'h0008_0004, 6'b001000, 32'h4);
        add(32'h0018_0010, 6'b000001, 32'h10);
        add(32'h001C_0011, 6'b000001, 32'h4_0011);
        // unmapped
        add(32'h000C_0000, 6'b000000, 32'h0);
        add(32'h000F_FFFF, 6'b000000, 32'h0);
        add(32'h0020_0000, 6'b000000, 32'h0);
        add(32'hFFFF_FFFF, 6'b000000, 32'h0);
        // back-to-back sweep across all regions
        add(32'h0000_0012, 6'b100000, 32'h12);
        add(32'h0004_0034, 6'b010000, 32'h34);
        add(32'h0008_0056, 6'b001000, 32'h56);
        add(32'h0010_0078, 6'b000100, 32'h78);
        add(32'h0014_009A, 6'b000010, 32'h9A);
        add(32'h0018_00BC, 6'b000001, 32'hBC);
        add(32'h000C_1234, 6'b000000, 32'h0);
        add(32'h0000_0001, 6'b100000, 32'h1);

        rst_n        = 1'b0;
        bus.i_addr_m = 32'h0004_0000;
        repeat (3) @(posedge clk);
        #1 check("reset_hold", bus.i_addr_m, 6'b0, 32'h0, 1'b0);

        rst_n = 1'b1;
        exp_q.push_back('{addr: 32'h0004_0000, en: 6'b010000, eff: 32'h0});
        @(posedge clk);
        #1;

        for (int i = 0; i < tbl.size(); i++) begin
            bus.i_addr_m = tbl[i].addr;
            exp_q.push_back(tbl[i]);
            @(posedge clk);
            #1;
        end

        // Asynchronous reset between edges while the stk decode is held.
        bus.i_addr_m = 32'h0015_0000;
        exp_q.push_back('{addr: 32'h0015_0000, en: 6'b000010, eff: 32'h1_0000});
        @(posedge clk);
        #4;
        rst_n = 1'b0;
        #1 check("async_reset", bus.i_addr_m, 6'b0, 32'h0, 1'b0);
        @(posedge clk);
        #1 check("reset_held_edge", bus.i_addr_m, 6'b0, 32'h0, 1'b0);

        rst_n        = 1'b1;
        bus.i_addr_m = 32'h0008_0004;
        exp_q.push_back('{addr: 32'h0008_0004, en: 6'b001000, eff: 32'h4});
        @(posedge clk);
        #1;

        for (int k = 0; k < 10 && exp_q.size() != 0; k++) @(posedge clk);
        #5;
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d pending, expected 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
